// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges EX results and LSU load responses onto one
// registered write port and tracks pending load destinations for decode hazard checks.
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int REG_NUM    = 32,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] ex_data_i,
    output logic              ex_stall_o,
    input  logic              lsu_issue_valid_i,
    input  logic [ADDR_W-1:0] lsu_issue_rd_i,
    output logic              lsu_issue_ready_o,
    input  logic              lsu_rsp_valid_i,
    input  logic [ADDR_W-1:0] lsu_rsp_rd_i,
    input  logic [DATA_W-1:0] lsu_rsp_data_i,
    output logic              lsu_rsp_ready_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              rd_busy_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

    logic [REG_NUM-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               ex_stall_q, ex_stall_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic ex_wants_s, rsp_ready_s, rsp_fire_s, issue_ready_s, issue_fire_s, blocked_s;
    logic illegal_issue_s, illegal_rsp_s;

    // Handshakes: a response is taken whenever EX does not claim the port, or EX is being held off.
    always_comb begin
        ex_wants_s    = ex_valid_i & (ex_rd_i != {ADDR_W{1'b0}});
        rsp_ready_s   = rst_n & (ex_stall_q | ~ex_wants_s);
        rsp_fire_s    = lsu_rsp_valid_i & rsp_ready_s;
        issue_ready_s = (out_cnt_q < CNT_MAX);
        issue_fire_s  = lsu_issue_valid_i & issue_ready_s;
        blocked_s     = lsu_rsp_valid_i & ~rsp_ready_s;
    end

    // Write-port select; idle cycles keep address/data and only drop the enable.
    always_comb begin
        if (ex_wants_s && !ex_stall_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ex_rd_i;
            wr_data_d = ex_data_i;
        end else if (rsp_fire_s && (lsu_rsp_rd_i != {ADDR_W{1'b0}})) begin
            wr_en_d   = 1'b1;
            wr_addr_d = lsu_rsp_rd_i;
            wr_data_d = lsu_rsp_data_i;
        end else begin
            wr_en_d   = 1'b0;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // Starvation: after STARVE_MAX blocked cycles EX is held off for one cycle so the load drains.
    always_comb begin
        if (blocked_s) begin
            starve_d   = (starve_q == STV_LAST) ? starve_q : (starve_q + STV_W'(1));
            ex_stall_d = (starve_q == STV_LAST);
        end else begin
            starve_d   = {STV_W{1'b0}};
            ex_stall_d = 1'b0;
        end
    end

    // Pending scoreboard (a new issue beats a same-cycle completion) and in-flight load count.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            pending_d[i] = (issue_fire_s && (lsu_issue_rd_i == ADDR_W'(i)) && (i != 0)) |
                           (pending_q[i] & ~(rsp_fire_s && (lsu_rsp_rd_i == ADDR_W'(i))));
        end
        if (issue_fire_s && !rsp_fire_s) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!issue_fire_s && rsp_fire_s && (out_cnt_q != {CNT_W{1'b0}})) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end else begin
            out_cnt_d = out_cnt_q;
        end
    end

    // Hazard queries see a completing load as already retired.
    always_comb begin
        rs1_busy_o = (rs1_addr_i != {ADDR_W{1'b0}}) & pending_q[rs1_addr_i] &
                     ~(rsp_fire_s & (lsu_rsp_rd_i == rs1_addr_i));
        rs2_busy_o = (rs2_addr_i != {ADDR_W{1'b0}}) & pending_q[rs2_addr_i] &
                     ~(rsp_fire_s & (lsu_rsp_rd_i == rs2_addr_i));
        rd_busy_o  = (rd_addr_i != {ADDR_W{1'b0}}) & pending_q[rd_addr_i] &
                     ~(rsp_fire_s & (lsu_rsp_rd_i == rd_addr_i));
        illegal_issue_s = issue_fire_s & (lsu_issue_rd_i != {ADDR_W{1'b0}}) &
                          pending_q[lsu_issue_rd_i] &
                          ~(rsp_fire_s & (lsu_rsp_rd_i == lsu_issue_rd_i));
        illegal_rsp_s   = rsp_fire_s & (out_cnt_q == {CNT_W{1'b0}});
    end

    // State registers; reset drops any in-flight loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= {REG_NUM{1'b0}};
            out_cnt_q  <= {CNT_W{1'b0}};
            starve_q   <= {STV_W{1'b0}};
            ex_stall_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= {DATA_W{1'b0}};
        end else begin
            pending_q  <= pending_d;
            out_cnt_q  <= out_cnt_d;
            starve_q   <= starve_d;
            ex_stall_q <= ex_stall_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign ex_stall_o        = ex_stall_q;
    assign lsu_issue_ready_o = issue_ready_s;
    assign lsu_rsp_ready_o   = rsp_ready_s;
    assign wr_en_o           = wr_en_q;
    assign wr_addr_o         = wr_addr_q;
    assign wr_data_o         = wr_data_q;

    rf_wb_arbiter_chk u_chk (
        .clk             (clk),
        .rst_n           (rst_n),
        .illegal_issue_i (illegal_issue_s),
        .illegal_rsp_i   (illegal_rsp_s)
    );
endmodule

// Protocol checker: decode must not reissue to a pending register, and the LSU must not
// answer a load that was never issued.
module rf_wb_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic illegal_issue_i,
    input logic illegal_rsp_i
);
    a_no_waw_issue: assert property (@(posedge clk) disable iff (!rst_n) !illegal_issue_i)
        else $error("load issued to a register that already has a pending load");
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n) !illegal_rsp_i)
        else $error("load response accepted with no load outstanding");
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, all checked against a
// model that tracks in-flight loads as a list and starvation as a blocked-cycle streak.
module tb_rf_wb_arbiter;
    localparam int DATA_W = 32, ADDR_W = 5, REG_NUM = 32, MAX_OUT = 4, STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic ex_valid, ex_stall, lsu_issue_valid, lsu_issue_ready, lsu_rsp_valid, lsu_rsp_ready;
    logic [ADDR_W-1:0] ex_rd, lsu_issue_rd, lsu_rsp_rd, rs1_addr, rs2_addr, rd_addr, wr_addr;
    logic [DATA_W-1:0] ex_data, lsu_rsp_data, wr_data;
    logic rs1_busy, rs2_busy, rd_busy, wr_en;

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM),
                    .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_rd_i(ex_rd), .ex_data_i(ex_data), .ex_stall_o(ex_stall),
        .lsu_issue_valid_i(lsu_issue_valid), .lsu_issue_rd_i(lsu_issue_rd),
        .lsu_issue_ready_o(lsu_issue_ready),
        .lsu_rsp_valid_i(lsu_rsp_valid), .lsu_rsp_rd_i(lsu_rsp_rd), .lsu_rsp_data_i(lsu_rsp_data),
        .lsu_rsp_ready_o(lsu_rsp_ready),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .rd_busy_o(rd_busy),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [ADDR_W-1:0] inflight[$];
    int                streak;
    logic              exp_stall, exp_wr_en, last_fire;
    logic [ADDR_W-1:0] exp_wr_addr;
    logic [DATA_W-1:0] exp_wr_data;
    int                stall_seen;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_pending(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        foreach (inflight[i]) if (inflight[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_rsp_ready();
        return exp_stall || !(ex_valid && ex_rd != 0);
    endfunction

    function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
        return is_pending(a) && !(lsu_rsp_valid && exp_rsp_ready() && lsu_rsp_rd == a);
    endfunction

    function automatic bit issue_legal(input logic [ADDR_W-1:0] a);
        return !is_pending(a) || (lsu_rsp_valid && exp_rsp_ready() && lsu_rsp_rd == a);
    endfunction

    task automatic model_reset();
        inflight.delete();
        streak = 0; exp_stall = 1'b0; exp_wr_en = 1'b0; last_fire = 1'b0;
        exp_wr_addr = '0; exp_wr_data = '0;
    endtask

    task automatic set_idle();
        ex_valid = 1'b0; lsu_issue_valid = 1'b0; lsu_rsp_valid = 1'b0;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic run_cycle();
        bit rdy, lfire, ifire, blocked;
        int idx;
        #1;
        rdy   = exp_rsp_ready();
        lfire = lsu_rsp_valid && rdy;
        ifire = lsu_issue_valid && (inflight.size() < MAX_OUT);
        check_val("rsp_ready", lsu_rsp_ready, rdy);
        check_val("issue_ready", lsu_issue_ready, inflight.size() < MAX_OUT);
        check_val("rs1_busy", rs1_busy, exp_busy(rs1_addr));
        check_val("rs2_busy", rs2_busy, exp_busy(rs2_addr));
        check_val("rd_busy", rd_busy, exp_busy(rd_addr));
        if (ex_valid && ex_rd != 0 && !exp_stall) begin
            exp_wr_en = 1'b1; exp_wr_addr = ex_rd; exp_wr_data = ex_data;
        end else if (lfire && lsu_rsp_rd != 0) begin
            exp_wr_en = 1'b1; exp_wr_addr = lsu_rsp_rd; exp_wr_data = lsu_rsp_data;
        end else begin
            exp_wr_en = 1'b0;
        end
        blocked = lsu_rsp_valid && !rdy;
        streak  = blocked ? streak + 1 : 0;
        exp_stall = (streak == STARVE_MAX);
        if (lfire) begin
            idx = -1;
            foreach (inflight[i]) if (idx < 0 && inflight[i] == lsu_rsp_rd) idx = i;
            if (idx >= 0) inflight.delete(idx);
        end
        if (ifire) inflight.push_back(lsu_issue_rd);
        last_fire = lfire;
        @(negedge clk);
        check_val("wr_en", wr_en, exp_wr_en);
        check_val("wr_addr", wr_addr, exp_wr_addr);
        check_val("wr_data", wr_data, exp_wr_data);
        check_val("ex_stall", ex_stall, exp_stall);
        if (ex_stall) stall_seen++;
    endtask

    task automatic issue_one(input logic [ADDR_W-1:0] rd);
        set_idle();
        lsu_issue_valid = 1'b1; lsu_issue_rd = rd;
        run_cycle();
        lsu_issue_valid = 1'b0;
    endtask

    task automatic respond_one(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        set_idle();
        lsu_rsp_valid = 1'b1; lsu_rsp_rd = rd; lsu_rsp_data = d;
        run_cycle();
        lsu_rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        ex_rd = '0; ex_data = '0; lsu_issue_rd = '0; lsu_rsp_rd = '0; lsu_rsp_data = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        model_reset();
        lsu_rsp_valid = 1'b1;
        #2;
        check_val("reset_rsp_ready", lsu_rsp_ready, 1'b0);
        check_val("reset_wr_en", wr_en, 1'b0);
        check_val("reset_ex_stall", ex_stall, 1'b0);
        check_val("reset_issue_ready", lsu_issue_ready, 1'b1);
        lsu_rsp_valid = 1'b0;
        #5 rst_n = 1'b1;
        @(negedge clk);

        // 1: EX only
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h0000_1234;
        run_cycle();
        check_val("t1_wr_data", wr_data, 32'h0000_1234);
        ex_valid = 1'b0;

        // 2: EX/LSU collision, EX first then LSU
        issue_one(5'd7);
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'hA;
        lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd7; lsu_rsp_data = 32'hB;
        run_cycle();
        ex_valid = 1'b0;
        run_cycle();
        check_val("t2_wr_addr", wr_addr, 5'd7);
        lsu_rsp_valid = 1'b0;
        run_cycle();

        // 3: starvation under continuous EX traffic
        issue_one(5'd9);
        ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'hCAFE_0001;
        lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd9; lsu_rsp_data = 32'h9999_0009;
        stall_seen = 0;
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            if (last_fire) lsu_rsp_valid = 1'b0;
        end
        check_val("t3_stall_once", stall_seen, 1);
        set_idle();
        run_cycle();

        // 4: scoreboard set/clear, set wins on same-cycle reissue
        rs1_addr = 5'd10;
        issue_one(5'd10);
        lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd10; lsu_rsp_data = 32'h10;
        lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd10;
        run_cycle();
        set_idle();
        run_cycle();
        check_val("t4_busy_again", rs1_busy, 1'b1);
        respond_one(5'd10, 32'h11);

        // 5: credits
        for (int r = 11; r <= 14; r++) issue_one(ADDR_W'(r));
        set_idle();
        run_cycle();
        respond_one(5'd11, 32'h11);
        lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd12; lsu_rsp_data = 32'h12;
        lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd15;
        run_cycle();
        set_idle();
        run_cycle();
        respond_one(5'd13, 32'h13);
        respond_one(5'd14, 32'h14);
        respond_one(5'd15, 32'h15);

        // 6: x0 writes and async reset with loads pending
        issue_one(5'd0);
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hDEAD;
        lsu_rsp_valid = 1'b1; lsu_rsp_rd = 5'd0; lsu_rsp_data = 32'hBEEF;
        run_cycle();
        set_idle();
        issue_one(5'd20);
        ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'h44;
        lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd21;
        run_cycle();
        set_idle();
        rs1_addr = 5'd20; rs2_addr = 5'd21;
        #1 rst_n = 1'b0;
        #1;
        check_val("t6_rst_wr_en", wr_en, 1'b0);
        check_val("t6_rst_busy1", rs1_busy, 1'b0);
        check_val("t6_rst_busy2", rs2_busy, 1'b0);
        check_val("t6_rst_issue_ready", lsu_issue_ready, 1'b1);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_cycle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!(ex_valid && exp_stall)) begin
                ex_valid = ($urandom_range(0, 3) != 0);
                ex_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom);
                ex_data  = $urandom;
            end
            if (!(lsu_rsp_valid && !last_fire)) begin
                if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp_rd    = inflight[$urandom_range(0, inflight.size() - 1)];
                    lsu_rsp_data  = $urandom;
                end else begin
                    lsu_rsp_valid = 1'b0;
                end
            end
            rs1_addr = ADDR_W'($urandom);
            rs2_addr = ADDR_W'($urandom);
            rd_addr  = ADDR_W'($urandom);
            lsu_issue_valid = ($urandom_range(0, 1) == 1);
            lsu_issue_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : ADDR_W'($urandom);
            if (!issue_legal(lsu_issue_rd)) lsu_issue_valid = 1'b0;
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
